xpt_sequencer: RTL and testbench

Phase-timer and opcode-fetch sequencer for the NORZ core. It owns the 5-bit execution phase timer (`XPT`/`notXPT`) and the opcode latch (`Source`/`notSource`) that drive every `DECODER_op_*` block. It also holds the M1 flag and prefix state, and gates the decoders through `Exec_Enable`. It sits between the bus interface and the decoder tree. It consumes the decoders' `PR_Reset_XPT`, `P2_Set_CM1` and `Pa_Ophd` strobes to close one phase group and open the next.

---
 rtl/xpt_sequencer_pkg.sv | 69 ++++++
 rtl/xpt_sequencer_if.sv | 46 ++++
 rtl/xpt_counter.sv | 56 +++++
 rtl/xpt_sequencer.sv | 156 +++++++++++++++
 tb/tb_xpt_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xpt_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : xpt_pkg
// Brief    : Shared types and constants for the NORZ phase-timer sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package xpt_pkg;

  localparam int XPT_W = 5;
  localparam int OP_W  = 8;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } xpt_state_e;

  localparam logic [XPT_W-1:0] XPT_T2         = 5'd1;
  localparam logic [XPT_W-1:0] XPT_T3         = 5'd2;
  localparam logic [XPT_W-1:0] XPT_FETCH_LAST = 5'd3;
  localparam logic [XPT_W-1:0] XPT_EXEC_FIRST = 5'd4;
  localparam logic [XPT_W-1:0] XPT_MAX        = 5'd31;

  localparam logic [OP_W-1:0] OP_PFX_CB = 8'hCB;
  localparam logic [OP_W-1:0] OP_PFX_ED = 8'hED;
  localparam logic [OP_W-1:0] OP_PFX_DD = 8'hDD;
  localparam logic [OP_W-1:0] OP_PFX_FD = 8'hFD;

  typedef struct packed {
    logic cb;
    logic ed;
    logic dd;
    logic fd;
  } prefix_t;

  function automatic logic is_prefix(input logic [OP_W-1:0] op);
    return (op == OP_PFX_CB) || (op == OP_PFX_ED) ||
           (op == OP_PFX_DD) || (op == OP_PFX_FD);
  endfunction

  // Index prefixes are mutually exclusive; CB stacks on top of DD/FD.
  function automatic prefix_t prefix_update(input logic [OP_W-1:0] op,
                                            input prefix_t         cur);
    prefix_t nxt;
    nxt = cur;
    case (op)
      OP_PFX_CB: nxt.cb = 1'b1;
      OP_PFX_ED: begin
        nxt.ed = 1'b1;
        nxt.dd = 1'b0;
        nxt.fd = 1'b0;
      end
      OP_PFX_DD: begin
        nxt.dd = 1'b1;
        nxt.fd = 1'b0;
      end
      OP_PFX_FD: begin
        nxt.fd = 1'b1;
        nxt.dd = 1'b0;
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xpt_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : xpt_sequencer_if
// Brief    : Bus/decoder-side signal bundle of the phase-timer sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface xpt_sequencer_if;
  import xpt_pkg::*;

  logic [OP_W-1:0]  DataIn;
  logic             Wait;
  logic             WaitPoint;
  logic             PR_Reset_XPT;
  logic             P2_Set_CM1;
  logic             Pa_Ophd;
  logic             Halt;
  logic             Int;

  logic [XPT_W-1:0] XPT;
  logic [XPT_W-1:0] notXPT;
  logic [OP_W-1:0]  Source;
  logic [OP_W-1:0]  notSource;
  logic             CM1;
  logic             Exec_Enable;
  logic             Prefix_CB;
  logic             Prefix_ED;
  logic             Prefix_DD;
  logic             Prefix_FD;
  logic             XPT_Err;

  modport master (
    output DataIn, Wait, WaitPoint, PR_Reset_XPT, P2_Set_CM1, Pa_Ophd, Halt, Int,
    input  XPT, notXPT, Source, notSource, CM1, Exec_Enable,
           Prefix_CB, Prefix_ED, Prefix_DD, Prefix_FD, XPT_Err
  );

  modport slave (
    input  DataIn, Wait, WaitPoint, PR_Reset_XPT, P2_Set_CM1, Pa_Ophd, Halt, Int,
    output XPT, notXPT, Source, notSource, CM1, Exec_Enable,
           Prefix_CB, Prefix_ED, Prefix_DD, Prefix_FD, XPT_Err
  );

endinterface

`default_nettype wire

// File: rtl/xpt_counter.sv
//------------------------------------------------------------------------------
// Module   : xpt_counter
// Brief    : 5-bit execution phase timer with load/hold/saturate and complement.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xpt_counter
  import xpt_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             ld4_i,
  input  logic             hold_i,
  output logic [XPT_W-1:0] xpt_o,
  output logic [XPT_W-1:0] not_xpt_o,
  output logic             at_max_o
);

  logic [XPT_W-1:0] xpt_q;
  logic [XPT_W-1:0] not_xpt_q;
  logic [XPT_W-1:0] xpt_d;

  assign at_max_o = (xpt_q == XPT_MAX);

  always_comb begin
    xpt_d = xpt_q;
    if (clr_i) begin
      xpt_d = '0;
    end else if (ld4_i) begin
      xpt_d = XPT_EXEC_FIRST;
    end else if (hold_i || at_max_o) begin
      xpt_d = xpt_q;
    end else begin
      xpt_d = xpt_q + 5'd1;
    end
  end

  // Complement is its own flop so both rails come straight from registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      xpt_q     <= '0;
      not_xpt_q <= '1;
    end else begin
      xpt_q     <= xpt_d;
      not_xpt_q <= ~xpt_d;
    end
  end

  assign xpt_o     = xpt_q;
  assign not_xpt_o = not_xpt_q;

endmodule

`default_nettype wire

// File: rtl/xpt_sequencer.sv
//------------------------------------------------------------------------------
// Module   : xpt_sequencer
// Brief    : Phase timer, opcode latch, M1/prefix state and decoder enable.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xpt_sequencer
  import xpt_pkg::*;
(
  input  logic           CLK,
  input  logic           notRESET,
  xpt_sequencer_if.slave bus
);

  xpt_state_e       state_q;
  xpt_state_e       state_d;
  logic             cm1_q;
  logic             cm1_d;
  logic             exen_q;
  logic             exen_d;
  logic [OP_W-1:0]  source_q;
  logic [OP_W-1:0]  nsource_q;
  logic [OP_W-1:0]  source_d;
  prefix_t          pfx_q;
  prefix_t          pfx_d;
  logic             err_q;
  logic             err_d;

  logic             w_clr;
  logic             w_ld4;
  logic             w_hold;
  logic             w_t2_wait;
  logic             w_at_max;
  logic [XPT_W-1:0] w_xpt;
  logic [XPT_W-1:0] w_nxpt;

  xpt_counter u_counter (
    .clk_i     (CLK),
    .rst_n_i   (notRESET),
    .clr_i     (w_clr),
    .ld4_i     (w_ld4),
    .hold_i    (w_hold),
    .xpt_o     (w_xpt),
    .not_xpt_o (w_nxpt),
    .at_max_o  (w_at_max)
  );

  assign w_t2_wait = bus.Wait && (w_xpt == XPT_T2);

  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      state_q <= ST_FETCH;
      cm1_q   <= 1'b1;
      exen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cm1_q   <= cm1_d;
      exen_q  <= exen_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    source_d = source_q;
    pfx_d    = pfx_q;
    err_d    = err_q;
    w_clr    = 1'b0;
    w_ld4    = 1'b0;
    w_hold   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (w_t2_wait) begin
          w_hold = 1'b1;
        end else if (w_xpt == XPT_FETCH_LAST) begin
          // A prefix byte restarts the fetch instead of entering EXEC.
          if (is_prefix(source_q)) begin
            w_clr = 1'b1;
            pfx_d = prefix_update(source_q, pfx_q);
          end else begin
            w_ld4   = 1'b1;
            state_d = ST_EXEC;
          end
        end else if (w_xpt == XPT_T3) begin
          source_d = bus.DataIn;
        end
      end
      ST_EXEC: begin
        if (bus.PR_Reset_XPT) begin
          w_clr = 1'b1;
          if (bus.Pa_Ophd) begin
            pfx_d = '0;
          end
          if (bus.Halt) begin
            state_d = ST_HALT;
          end else if (bus.P2_Set_CM1) begin
            state_d = ST_FETCH;
          end
        end else if (bus.Wait && bus.WaitPoint) begin
          w_hold = 1'b1;
        end else if (w_at_max) begin
          err_d = 1'b1;
        end
      end
      ST_HALT: begin
        // Dummy M1 loop: timer wraps 0..3, opcode latch untouched.
        if (w_t2_wait) begin
          w_hold = 1'b1;
        end else if (w_xpt == XPT_FETCH_LAST) begin
          w_clr = 1'b1;
          if (bus.Int) begin
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_FETCH;
        w_clr   = 1'b1;
      end
    endcase
  end

  always_comb begin
    cm1_d  = (state_d != ST_EXEC);
    exen_d = (state_d == ST_EXEC);
  end

  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      source_q  <= '0;
      nsource_q <= '1;
      pfx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      source_q  <= source_d;
      nsource_q <= ~source_d;
      pfx_q     <= pfx_d;
      err_q     <= err_d;
    end
  end

  assign bus.XPT         = w_xpt;
  assign bus.notXPT      = w_nxpt;
  assign bus.Source      = source_q;
  assign bus.notSource   = nsource_q;
  assign bus.CM1         = cm1_q;
  assign bus.Exec_Enable = exen_q;
  assign bus.Prefix_CB   = pfx_q.cb;
  assign bus.Prefix_ED   = pfx_q.ed;
  assign bus.Prefix_DD   = pfx_q.dd;
  assign bus.Prefix_FD   = pfx_q.fd;
  assign bus.XPT_Err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_xpt_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_xpt_sequencer
// Brief    : Self-checking bench for xpt_sequencer with a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_xpt_sequencer;

  logic CLK = 1'b0;
  logic notRESET = 1'b1;

  xpt_sequencer_if bus ();

  xpt_sequencer dut (
    .CLK      (CLK),
    .notRESET (notRESET),
    .bus      (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int M_FETCH = 0;
  localparam int M_EXEC  = 1;
  localparam int M_HALT  = 2;

  int         m_mode;
  int         m_xpt;
  logic [7:0] m_op;
  logic       m_cb, m_ed, m_dd, m_fd, m_err;

  task automatic model_reset();
    m_mode = M_FETCH;
    m_xpt  = 0;
    m_op   = 8'h00;
    {m_cb, m_ed, m_dd, m_fd, m_err} = 5'b0;
  endtask

  // One clock edge of the sequencer's behaviour, from the rules directly.
  task automatic model_step();
    if (m_mode == M_EXEC) begin
      if (bus.PR_Reset_XPT) begin
        m_xpt = 0;
        if (bus.Pa_Ophd) {m_cb, m_ed, m_dd, m_fd} = 4'b0;
        if (bus.Halt) m_mode = M_HALT;
        else if (bus.P2_Set_CM1) m_mode = M_FETCH;
      end else if (bus.Wait && bus.WaitPoint) begin
      end else if (m_xpt == 31) begin
        m_err = 1'b1;
      end else begin
        m_xpt = m_xpt + 1;
      end
    end else if (bus.Wait && m_xpt == 1) begin
    end else if (m_xpt == 3) begin
      m_xpt = 0;
      if (m_mode == M_HALT) begin
        if (bus.Int) m_mode = M_FETCH;
      end else begin
        case (m_op)
          8'hCB: m_cb = 1'b1;
          8'hED: begin m_ed = 1'b1; m_dd = 1'b0; m_fd = 1'b0; end
          8'hDD: begin m_dd = 1'b1; m_fd = 1'b0; end
          8'hFD: begin m_fd = 1'b1; m_dd = 1'b0; end
          default: begin m_xpt = 4; m_mode = M_EXEC; end
        endcase
      end
    end else begin
      if (m_mode == M_FETCH && m_xpt == 2) m_op = bus.DataIn;
      m_xpt = m_xpt + 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.DataIn       = 8'h00;
    bus.Wait         = 1'b0;
    bus.WaitPoint    = 1'b0;
    bus.PR_Reset_XPT = 1'b0;
    bus.P2_Set_CM1   = 1'b0;
    bus.Pa_Ophd      = 1'b0;
    bus.Halt         = 1'b0;
    bus.Int          = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    notRESET = 1'b0;
    @(posedge CLK);
    #1;
    model_reset();
    notRESET = 1'b1;
  endtask

  task automatic test_reset();
    logic [32:0] act;
    logic [32:0] exp;
    idle_inputs();
    notRESET = 1'b0;
    #2;
    exp = {5'd0, 5'h1F, 8'h00, 8'hFF, 1'b1, 1'b0, 4'b0000, 1'b0};
    act = {bus.XPT, bus.notXPT, bus.Source, bus.notSource, bus.CM1, bus.Exec_Enable,
           bus.Prefix_CB, bus.Prefix_ED, bus.Prefix_DD, bus.Prefix_FD, bus.XPT_Err};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", act, exp);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (bus.XPT !== 5'd0 || bus.notXPT !== 5'h1F) begin
      n_fail++;
      $display("FAIL reset_held: XPT=%0d notXPT=%h expected 0/1f", bus.XPT, bus.notXPT);
    end
    model_reset();
    notRESET = 1'b1;
    tick();
    n_checks++;
    if (bus.XPT !== 5'd1) begin
      n_fail++;
      $display("FAIL reset_release: XPT=%0d expected 1", bus.XPT);
    end
  endtask

  task automatic test_fetch();
    apply_reset();
    bus.DataIn = 8'hC5;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (bus.XPT !== i[4:0] || bus.CM1 !== 1'b1) begin
        n_fail++;
        $display("FAIL fetch_t%0d: XPT=%0d CM1=%b expected %0d/1", i, bus.XPT, bus.CM1, i);
      end
    end
    n_checks++;
    if (bus.Source !== 8'hC5) begin
      n_fail++;
      $display("FAIL fetch_source: Source=%h expected c5", bus.Source);
    end
    tick();
    n_checks++;
    if (bus.XPT !== 5'd4 || bus.notXPT !== 5'h1B || bus.Exec_Enable !== 1'b1 ||
        bus.CM1 !== 1'b0 || bus.notSource !== 8'h3A) begin
      n_fail++;
      $display("FAIL fetch_exec: XPT=%0d notXPT=%h EN=%b CM1=%b notSource=%h expected 4/1b/1/0/3a",
               bus.XPT, bus.notXPT, bus.Exec_Enable, bus.CM1, bus.notSource);
    end
  endtask

  task automatic test_wait();
    apply_reset();
    bus.DataIn = 8'h3C;
    tick();
    bus.Wait = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.XPT !== 5'd1) begin
      n_fail++;
      $display("FAIL wait_hold: XPT=%0d expected 1", bus.XPT);
    end
    bus.Wait = 1'b0;
    tick();
    n_checks++;
    if (bus.XPT !== 5'd2 || bus.Source !== 8'h00) begin
      n_fail++;
      $display("FAIL wait_t3: XPT=%0d Source=%h expected 2/00", bus.XPT, bus.Source);
    end
    tick();
    n_checks++;
    if (bus.XPT !== 5'd3 || bus.Source !== 8'h3C) begin
      n_fail++;
      $display("FAIL wait_latch: XPT=%0d Source=%h expected 3/3c", bus.XPT, bus.Source);
    end
  endtask

  task automatic test_prefix();
    apply_reset();
    bus.DataIn = 8'hDD;
    repeat (4) tick();
    n_checks++;
    if (bus.XPT !== 5'd0 || bus.Prefix_DD !== 1'b1 || bus.CM1 !== 1'b1) begin
      n_fail++;
      $display("FAIL prefix_dd: XPT=%0d DD=%b CM1=%b expected 0/1/1", bus.XPT, bus.Prefix_DD, bus.CM1);
    end
    bus.DataIn = 8'hCB;
    repeat (4) tick();
    n_checks++;
    if (bus.Prefix_CB !== 1'b1 || bus.Prefix_DD !== 1'b1 || bus.Exec_Enable !== 1'b0) begin
      n_fail++;
      $display("FAIL prefix_cb: CB=%b DD=%b EN=%b expected 1/1/0", bus.Prefix_CB, bus.Prefix_DD, bus.Exec_Enable);
    end
    bus.DataIn = 8'h06;
    repeat (4) tick();
    n_checks++;
    if (bus.XPT !== 5'd4 || bus.Exec_Enable !== 1'b1 || bus.Source !== 8'h06 ||
        bus.Prefix_CB !== 1'b1 || bus.Prefix_DD !== 1'b1) begin
      n_fail++;
      $display("FAIL prefix_exec: XPT=%0d EN=%b Source=%h CB=%b DD=%b expected 4/1/06/1/1",
               bus.XPT, bus.Exec_Enable, bus.Source, bus.Prefix_CB, bus.Prefix_DD);
    end
    bus.PR_Reset_XPT = 1'b1;
    bus.Pa_Ophd      = 1'b1;
    bus.P2_Set_CM1   = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.XPT !== 5'd0 || bus.CM1 !== 1'b1 || bus.Exec_Enable !== 1'b0 ||
        {bus.Prefix_CB, bus.Prefix_ED, bus.Prefix_DD, bus.Prefix_FD} !== 4'b0) begin
      n_fail++;
      $display("FAIL prefix_clear: XPT=%0d CM1=%b EN=%b pfx=%b%b%b%b expected 0/1/0/0000",
               bus.XPT, bus.CM1, bus.Exec_Enable, bus.Prefix_CB, bus.Prefix_ED, bus.Prefix_DD, bus.Prefix_FD);
    end
  endtask

  task automatic test_exec();
    apply_reset();
    bus.DataIn = 8'h00;
    repeat (4) tick();
    repeat (6) tick();
    n_checks++;
    if (bus.XPT !== 5'd10) begin
      n_fail++;
      $display("FAIL exec_count: XPT=%0d expected 10", bus.XPT);
    end
    bus.PR_Reset_XPT = 1'b1;
    tick();
    bus.PR_Reset_XPT = 1'b0;
    n_checks++;
    if (bus.XPT !== 5'd0 || bus.CM1 !== 1'b0 || bus.Exec_Enable !== 1'b1) begin
      n_fail++;
      $display("FAIL exec_group: XPT=%0d CM1=%b EN=%b expected 0/0/1", bus.XPT, bus.CM1, bus.Exec_Enable);
    end
    repeat (31) tick();
    n_checks++;
    if (bus.XPT !== 5'd31 || bus.XPT_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_top: XPT=%0d Err=%b expected 31/0", bus.XPT, bus.XPT_Err);
    end
    tick();
    n_checks++;
    if (bus.XPT !== 5'd31 || bus.notXPT !== 5'd0 || bus.XPT_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL exec_saturate: XPT=%0d notXPT=%h Err=%b expected 31/00/1", bus.XPT, bus.notXPT, bus.XPT_Err);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    bus.DataIn = 8'h76;
    repeat (4) tick();
    bus.PR_Reset_XPT = 1'b1;
    bus.Halt         = 1'b1;
    bus.P2_Set_CM1   = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.XPT !== 5'd0 || bus.CM1 !== 1'b1 || bus.Exec_Enable !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_enter: XPT=%0d CM1=%b EN=%b expected 0/1/0", bus.XPT, bus.CM1, bus.Exec_Enable);
    end
    bus.DataIn = 8'hAA;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (bus.XPT !== 5'(i % 4) || bus.Source !== 8'h76 || bus.CM1 !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_loop%0d: XPT=%0d Source=%h CM1=%b expected %0d/76/1", i, bus.XPT, bus.Source, bus.CM1, i % 4);
      end
    end
    tick();
    bus.Int = 1'b1;
    repeat (3) tick();
    bus.Int = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.XPT !== 5'd3 || bus.Source !== 8'hAA) begin
      n_fail++;
      $display("FAIL halt_wake: XPT=%0d Source=%h expected 3/aa", bus.XPT, bus.Source);
    end
    tick();
    n_checks++;
    if (bus.XPT !== 5'd4 || bus.Exec_Enable !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_exec: XPT=%0d EN=%b expected 4/1", bus.XPT, bus.Exec_Enable);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.DataIn = 8'h21;
    repeat (6) tick();
    n_checks++;
    if (bus.XPT !== 5'd6 || bus.Exec_Enable !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: XPT=%0d EN=%b expected 6/1", bus.XPT, bus.Exec_Enable);
    end
    #2;
    notRESET = 1'b0;
    #1;
    n_checks++;
    if (bus.XPT !== 5'd0 || bus.notXPT !== 5'h1F || bus.CM1 !== 1'b1 || bus.Exec_Enable !== 1'b0 ||
        bus.Source !== 8'h00 || bus.notSource !== 8'hFF) begin
      n_fail++;
      $display("FAIL areset_immediate: XPT=%0d notXPT=%h CM1=%b EN=%b Source=%h notSource=%h expected 0/1f/1/0/00/ff",
               bus.XPT, bus.notXPT, bus.CM1, bus.Exec_Enable, bus.Source, bus.notSource);
    end
    @(posedge CLK);
    #1;
    model_reset();
    notRESET = 1'b1;
    tick();
    n_checks++;
    if (bus.XPT !== 5'd1 || bus.CM1 !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_release: XPT=%0d CM1=%b expected 1/1", bus.XPT, bus.CM1);
    end
  endtask

  task automatic test_random();
    logic [32:0] act;
    logic [32:0] exp;
    logic [4:0]  mx;
    logic [7:0]  pfx_ops [4];
    pfx_ops[0] = 8'hCB;
    pfx_ops[1] = 8'hED;
    pfx_ops[2] = 8'hDD;
    pfx_ops[3] = 8'hFD;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.DataIn = pfx_ops[$urandom_range(0, 3)];
      else bus.DataIn = 8'($urandom);
      bus.Wait         = ($urandom_range(0, 3) == 0);
      bus.WaitPoint    = ($urandom_range(0, 1) == 0);
      bus.PR_Reset_XPT = ($urandom_range(0, 5) == 0);
      bus.P2_Set_CM1   = ($urandom_range(0, 1) == 0);
      bus.Pa_Ophd      = ($urandom_range(0, 1) == 0);
      bus.Halt         = ($urandom_range(0, 3) == 0);
      bus.Int          = ($urandom_range(0, 2) == 0);
      tick();
      mx  = m_xpt[4:0];
      exp = {mx, ~mx, m_op, ~m_op, (m_mode != M_EXEC), (m_mode == M_EXEC),
             m_cb, m_ed, m_dd, m_fd, m_err};
      act = {bus.XPT, bus.notXPT, bus.Source, bus.notSource, bus.CM1, bus.Exec_Enable,
             bus.Prefix_CB, bus.Prefix_ED, bus.Prefix_DD, bus.Prefix_FD, bus.XPT_Err};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", c, act, exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #2;
    test_reset();
    test_fetch();
    test_wait();
    test_prefix();
    test_exec();
    test_halt();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
